program_loader: RTL
===================

Name: program_loader

Overview:
Byte-stream boot loader that sits directly upstream of the CPU. It fills the CPU instruction memory through the CPU's write port (`i_instr_addr`, `i_instr`, `i_we`), then pulses CPU reset and raises `i_ON`. The byte source is a UART receiver or a host bridge that delivers one byte per valid pulse. Frames are count-prefixed and XOR-checksummed. The CPU never runs a partially or wrongly loaded program.

Parameters:
- `TIMEOUT`, 50000: maximum idle cycles between bytes inside a frame before the frame is aborted.
- `RST_CYCLES`, 2: number of cycles `o_cpu_rst` is held high before `o_ON` rises; must be at least 1.

Ports:
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_byte`  in  8  incoming byte; valid only while `i_byte_valid` is high.
- `i_byte_valid`  in  1  one-cycle strobe per byte; may be asserted on back-to-back cycles.
- `o_instr_addr`  out  8  instruction memory write address, to CPU `i_instr_addr`.
- `o_instr`  out  16  instruction word, to CPU `i_instr`.
- `o_we`  out  1  instruction memory write enable, to CPU `i_we`.
- `o_cpu_rst`  out  1  CPU reset, to CPU `i_rst`.
- `o_ON`  out  1  CPU run enable, to CPU `i_ON`.
- `o_busy`  out  1  high while a frame is in progress or boot is in progress.
- `o_done`  out  1  one-cycle pulse on entry to RUN.
- `o_err`  out  1  sticky error flag for checksum failure or timeout.

Behaviour:
- Frame format:
  - Header byte N: number of words, where 0 means 256.
  - 2N data bytes, high byte first.
  - One checksum byte equal to the XOR of the header and all data bytes.
- Reset (`i_rst`=1 at a clock edge): state IDLE; all outputs 0; address and word counters 0; checksum 0. A reset mid-frame aborts the frame; words already written stay in memory, and no further writes occur.
- States:
  - IDLE: `o_ON`=0. A valid byte is taken as the header: load the count, set checksum = byte, set address = 0, go to HI.
  - HI: a valid byte is latched as the high byte; checksum ^= byte; go to LO.
  - LO: on a valid byte, register `o_instr` = {hi, byte} and `o_instr_addr` = current address, and assert `o_we` for exactly one cycle, the cycle after sampling. Checksum ^= byte; address += 1; remaining -= 1. Go to CHK if this was the last word, else HI.
  - CHK: on a valid byte, go to BOOT if byte == checksum, else ERR.
  - BOOT: `o_cpu_rst`=1 for `RST_CYCLES` cycles, starting the cycle after the checksum byte is sampled. In the cycle `o_cpu_rst` falls, `o_ON`=1, `o_done`=1 for one cycle, and the state becomes RUN.
  - RUN: `o_ON` stays 1. A valid byte is a new header: `o_ON` drops to 0 on the next cycle; header handling is as in IDLE; go to HI.
  - ERR: `o_err`=1 and `o_ON`=0. A valid byte is a new header: clear `o_err`, handle as in IDLE, go to HI.
- Timeout:
  - In HI, LO and CHK, an idle counter increments on every cycle without `i_byte_valid` and clears on every valid byte.
  - When the counter reaches `TIMEOUT`, go to ERR.
  - The counter is not active in IDLE, RUN or ERR.
- Registered outputs:
  - `o_instr_addr` and `o_instr` are stable during the `o_we` cycle and hold their values afterwards.
  - `o_we` is never high outside the cycle following an LO byte.
- `o_busy` = 1 in HI, LO, CHK and BOOT, else 0.
- `i_byte_valid` in BOOT is ignored: the byte is dropped and has no effect.
- Address wrap: N=0 writes addresses 0..255; the 8-bit address wraps to 0 after the last write, which is harmless.
- Back-to-back bytes, one per cycle, must load with no byte loss.

Test Plan:
- Normal load: send `02 12 34 AB CD 42` → `o_we` pulses with (addr 0, 0x1234) and (addr 1, 0xABCD); `o_cpu_rst` high for 2 cycles; then `o_ON`=1 and `o_done` pulses; `o_err`=0; CPU `o_WREG` behaves per the loaded program.
- Bad checksum: send `02 12 34 AB CD 43` → two writes occur; state ERR with `o_err`=1; `o_ON`=0; `o_cpu_rst` never asserted.
- Timeout: with `TIMEOUT`=20, send `01 12` and then nothing → ERR after 20 idle cycles; `o_we` never pulses; `o_busy` falls.
- Reload during RUN: after a normal load, send `01 00 00 01` → `o_ON` falls on the cycle after the header; one write of 0x0000 to addr 0; reboot; `o_ON`=1 again.
- Error recovery and back-to-back input: from ERR, send `01 FF EE 10` on consecutive cycles → `o_err` clears on the header; addr 0 = 0xFFEE; boot completes.
- Mid-frame reset plus full count: assert `i_rst` after `03 11 22` → all outputs 0 and no further `o_we`. Then send header 00, 512 bytes and the correct checksum → 256 writes at addresses 0..255 in order, then boot.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream boot loader: receives a count-prefixed, XOR-checksummed frame,
// writes the words into CPU instruction memory, then boots the CPU.
module program_loader #(
    parameter int unsigned TIMEOUT    = 50000,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [7:0]  o_instr_addr,
    output logic [15:0] o_instr,
    output logic        o_we,
    output logic        o_cpu_rst,
    output logic        o_ON,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam int unsigned BOOT_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned REM_W  = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_CHK,
        S_BOOT,
        S_RUN,
        S_ERR
    } state_t;

    state_t              state_q;
    logic [REM_W-1:0]    rem_q;
    logic [7:0]          addr_q;
    logic [7:0]          hi_q;
    logic [7:0]          csum_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [BOOT_W-1:0]   boot_q;
    logic [7:0]          instr_addr_q;
    logic [15:0]         instr_q;
    logic                we_q;
    logic                cpu_rst_q;
    logic                on_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                in_frame_c;

    assign in_frame_c = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_CHK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            addr_q       <= '0;
            hi_q         <= '0;
            csum_q       <= '0;
            idle_q       <= '0;
            boot_q       <= '0;
            instr_addr_q <= '0;
            instr_q      <= '0;
            we_q         <= 1'b0;
            cpu_rst_q    <= 1'b0;
            on_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;

            // Inter-byte watchdog inside a frame; a valid byte clears it below.
            if (in_frame_c && !i_byte_valid) begin
                if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    idle_q  <= '0;
                end else begin
                    idle_q <= idle_q + IDLE_W'(1);
                end
            end

            unique case (state_q)
                S_IDLE, S_RUN, S_ERR: begin
                    if (i_byte_valid) begin
                        rem_q   <= (i_byte == 8'd0) ? REM_W'(256) : REM_W'(i_byte);
                        csum_q  <= i_byte;
                        addr_q  <= '0;
                        idle_q  <= '0;
                        on_q    <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (i_byte_valid) begin
                        hi_q    <= i_byte;
                        csum_q  <= csum_q ^ i_byte;
                        idle_q  <= '0;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    if (i_byte_valid) begin
                        instr_q      <= {hi_q, i_byte};
                        instr_addr_q <= addr_q;
                        we_q         <= 1'b1;
                        csum_q       <= csum_q ^ i_byte;
                        addr_q       <= addr_q + 8'd1;
                        rem_q        <= rem_q - REM_W'(1);
                        idle_q       <= '0;
                        state_q      <= (rem_q == REM_W'(1)) ? S_CHK : S_HI;
                    end
                end
                S_CHK: begin
                    if (i_byte_valid) begin
                        idle_q <= '0;
                        if (i_byte == csum_q) begin
                            cpu_rst_q <= 1'b1;
                            boot_q    <= '0;
                            state_q   <= S_BOOT;
                        end else begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_BOOT: begin
                    // Incoming bytes are dropped while the CPU is held in reset.
                    if (boot_q == BOOT_W'(RST_CYCLES - 1)) begin
                        cpu_rst_q <= 1'b0;
                        on_q      <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_RUN;
                    end else begin
                        boot_q <= boot_q + BOOT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_instr_addr = instr_addr_q;
    assign o_instr      = instr_q;
    assign o_we         = we_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_ON         = on_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule
